uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller for the UART receive path. It combines the frame state machine, oversampling edge/bit counters, 3-point majority-vote sampler, deserializer and parity/stop checkers in one block. Compared with the earlier receive FSM it adds:
- configurable data width
- selectable even/odd/no parity
- 1 or 2 stop bits
- error flags, busy, and back-to-back frame reception

It sits between the RX pin synchroniser and the RX data consumer.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 96 +++++++++
 tb/tb_uart_rx_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART receive path
package uart_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
   localparam state_t DONE   = 3'd5;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   localparam int MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and 3-point majority vote
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  pre,
   input  logic                  rx,
   input  logic [PRESCALE_W-1:0] ps,
   output logic                  bit_tick,
   output logic                  sampled_bit
);
   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
   logic [PRESCALE_W-1:0] edge_cnt, half;
   logic [2:0] smp;
   logic third;
   assign half = ps >> 1;
   assign bit_tick = run && edge_cnt == ps - ONE;
   // at the minimum prescale the third sample coincides with the tick, so use it live
   assign third = edge_cnt == half + ONE ? rx : smp[2];
   assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & third) | (smp[1] & third);
   // pre: a back-to-back start bit has already been low for one clock
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         edge_cnt <= '0;
         smp <= '0;
      end else begin
         edge_cnt <= run ? (bit_tick ? '0 : edge_cnt + ONE) : (pre ? ONE : '0);
         if (run && edge_cnt == half - ONE) smp[0] <= rx;
         if (run && edge_cnt == half) smp[1] <= rx;
         if (run && edge_cnt == half + ONE) smp[2] <= rx;
      end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM with deserializer, parity and stop-bit checking
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);
   localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(MIN_PRESCALE);
   state_t state, nxt;
   logic run, restart, start_go, tick, smp_bit, stop_last;
   logic par_flag, stp_flag, dv_n, pe_n, se_n;
   logic par_en_q, par_typ_q, stop2_q;
   logic [PRESCALE_W-1:0] ps_q;
   logic [3:0] bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   assign run = state != IDLE && state != DONE;
   assign restart = state == DONE && !RX_IN;
   assign start_go = (state == IDLE || state == DONE) && !RX_IN;
   assign stop_last = state == STOP && tick && bit_cnt == {3'b0, stop2_q};
   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_smp (
      .clk(clk),
      .rst(rst),
      .run(run),
      .pre(restart),
      .rx(RX_IN),
      .ps(ps_q),
      .bit_tick(tick),
      .sampled_bit(smp_bit)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (!RX_IN) nxt = START;
         START:   if (tick) nxt = smp_bit ? IDLE : DATA;
         DATA:    if (tick && bit_cnt == 4'(DATA_WIDTH - 1)) nxt = par_en_q ? PARITY : STOP;
         PARITY:  if (tick) nxt = STOP;
         STOP:    if (stop_last) nxt = DONE;
         DONE:    nxt = RX_IN ? IDLE : START;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      busy = state != IDLE;
      se_n = stop_last && (stp_flag || !smp_bit);
      pe_n = stop_last && par_flag;
      dv_n = stop_last && !se_n && !par_flag;
   end
   // flags are registered on the STOP->DONE edge so they are high exactly for the DONE clock
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bit_cnt <= '0;
         ps_q <= PS_MIN;
         par_en_q <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q <= 1'b0;
         shreg <= '0;
         par_flag <= 1'b0;
         stp_flag <= 1'b0;
         P_DATA <= '0;
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stp_err <= 1'b0;
      end else begin
         bit_cnt <= nxt != state ? '0 : bit_cnt + {3'b0, tick};
         if (start_go) begin
            ps_q <= prescale < PS_MIN ? PS_MIN : prescale;
            par_en_q <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q <= STOP2;
         end
         if (state == DATA && tick) shreg <= {smp_bit, shreg[DATA_WIDTH-1:1]};
         par_flag <= state == DONE ? 1'b0 :
                     state == PARITY && tick ? smp_bit != ((^shreg) ^ (par_typ_q == PAR_ODD)) : par_flag;
         stp_flag <= state == DONE ? 1'b0 : (state == STOP && tick && !smp_bit) ? 1'b1 : stp_flag;
         if (dv_n) P_DATA <= shreg;
         data_valid <= dv_n;
         par_err <= pe_n;
         stp_err <= se_n;
      end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames checked against a frame-level timing/result model
module tb_uart_rx_ctrl;
   logic clk = 0, rst = 1, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0, STOP2 = 0;
   logic [5:0] prescale = 6'd8;
   logic [7:0] P_DATA;
   logic data_valid, par_err, stp_err, busy;
   int total = 0, bad = 0, cyc = 0;
   typedef struct {
      int per;
      logic dv, pe, se;
      logic [7:0] d;
   } ev_t;
   ev_t q[$];
   logic [7:0] exp_pdata = 8'h00;
   int dv_per[$];
   logic [7:0] dv_dat[$];

   uart_rx_ctrl dut (
      .clk(clk), .rst(rst), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA), .data_valid(data_valid),
      .par_err(par_err), .stp_err(stp_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // period p is the clock period that ends with posedge number p (cyc == p after it)
   always @(negedge clk) begin : cmp
      int per;
      logic edv, epe, ese;
      per = cyc + 1;
      edv = 0; epe = 0; ese = 0;
      while (q.size() > 0 && q[0].per < per) begin
         chk("missed_frame_end", 32'(per), 32'(q[0].per));
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].per == per) begin
         edv = q[0].dv; epe = q[0].pe; ese = q[0].se;
         if (edv) exp_pdata = q[0].d;
         void'(q.pop_front());
      end
      chk("data_valid", data_valid, edv);
      chk("par_err", par_err, epe);
      chk("stp_err", stp_err, ese);
      chk("P_DATA", P_DATA, exp_pdata);
      if (data_valid) begin
         dv_per.push_back(per);
         dv_dat.push_back(P_DATA);
      end
   end

   task automatic idle(input int n);
      RX_IN = 1;
      repeat (n) @(negedge clk);
   endtask

   task automatic at_period(input int p);
      int g = 0;
      while (cyc + 1 < p && g < 20000) begin
         @(negedge clk);
         g++;
      end
      chk("reach_period", 32'(cyc + 1), 32'(p));
   endtask

   // Drives one frame from a negedge; the model result is due 1 + ps*bits periods after the start period
   task automatic send_frame(input logic [7:0] d, input logic [5:0] ps_in, input logic pen, ptyp, st2,
                             input logic pbit, input logic [1:0] stops, input int abort_at,
                             input bit scramble, output int p0);
      logic bits[$];
      int ps_eff;
      ev_t e;
      ps_eff = ps_in < 4 ? 4 : int'(ps_in);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(stops[0]);
      if (st2) bits.push_back(stops[1]);
      prescale = ps_in; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = st2;
      p0 = cyc + 1;
      for (int k = 0; k < bits.size(); k++) begin
         RX_IN = bits[k];
         if (scramble && k == 3) begin
            prescale = 6'd12; PAR_EN = ~pen; PAR_TYP = ~ptyp; STOP2 = ~st2;
         end
         if (abort_at >= 0 && k == abort_at + 1) begin
            repeat (ps_eff / 2) @(negedge clk);
            #2 rst = 0;
            q.delete();
            exp_pdata = 8'h00;
            #1 chk("reset_mid_frame", {20'h0, P_DATA, data_valid, par_err, stp_err, busy}, 32'h0);
            RX_IN = 1;
            @(negedge clk);
            #2 rst = 1;
            @(negedge clk);
            return;
         end
         repeat (ps_eff) @(negedge clk);
      end
      e.pe = pen && (pbit != ((^d) ^ ptyp));
      e.se = !stops[0] || (st2 && !stops[1]);
      e.dv = !e.pe && !e.se;
      e.d = d;
      e.per = p0 + 1 + ps_eff * bits.size();
      q.push_back(e);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int p, n0;
      #1 rst = 0;
      #11 chk("reset_state", {20'h0, P_DATA, data_valid, par_err, stp_err, busy}, 32'h0);
      #11 rst = 1;
      @(negedge clk);
      idle(3);
      // good frame, even parity, config scrambled mid-frame
      send_frame(8'hA5, 6'd8, 1, 0, 0, 0, 2'b11, -1, 1, p);
      at_period(p + 89);
      chk("t1_dv", data_valid, 1);
      chk("t1_data", P_DATA, 8'hA5);
      at_period(p + 90);
      chk("t1_dv_one_clk", data_valid, 0);
      idle(4);
      // wrong parity (odd expected, 0 sent)
      send_frame(8'hA5, 6'd8, 1, 1, 0, 0, 2'b11, -1, 0, p);
      at_period(p + 89);
      chk("t2_par_err", par_err, 1);
      chk("t2_dv", data_valid, 0);
      idle(4);
      send_frame(8'h5A, 6'd8, 1, 1, 0, 0, 2'b11, -1, 0, p);
      at_period(p + 89);
      chk("t2b_par_err", par_err, 1);
      chk("t2b_data_held", P_DATA, 8'hA5);
      idle(4);
      // start glitch at prescale 16
      prescale = 6'd16;
      RX_IN = 0;
      p = cyc + 1;
      repeat (3) @(negedge clk);
      RX_IN = 1;
      at_period(p + 16);
      chk("t3_busy_edge15", busy, 1);
      at_period(p + 17);
      chk("t3_busy_after", busy, 0);
      idle(4);
      send_frame(8'h3C, 6'd16, 0, 0, 0, 0, 2'b11, -1, 0, p);
      at_period(p + 161);
      chk("t3_data", P_DATA, 8'h3C);
      idle(4);
      // two stop bits, second one low
      send_frame(8'h5A, 6'd8, 0, 0, 1, 0, 2'b01, -1, 0, p);
      at_period(p + 89);
      chk("t4_stp_err", stp_err, 1);
      chk("t4_dv", data_valid, 0);
      idle(4);
      // back-to-back frames
      n0 = dv_per.size();
      send_frame(8'h11, 6'd8, 0, 0, 0, 0, 2'b11, -1, 0, p);
      send_frame(8'hEE, 6'd8, 0, 0, 0, 0, 2'b11, -1, 0, p);
      idle(4);
      chk("t5_count", 32'(dv_per.size() - n0), 2);
      if (dv_per.size() >= n0 + 2) begin
         chk("t5_gap", 32'(dv_per[n0+1] - dv_per[n0]), 80);
         chk("t5_first", dv_dat[n0], 8'h11);
         chk("t5_second", dv_dat[n0+1], 8'hEE);
      end
      // reset during data bit 3, then a clean frame
      send_frame(8'hC3, 6'd8, 0, 0, 0, 0, 2'b11, 3, 0, p);
      idle(3);
      send_frame(8'h7E, 6'd8, 0, 0, 0, 0, 2'b11, -1, 0, p);
      at_period(p + 81);
      chk("t6_data", P_DATA, 8'h7E);
      idle(4);
      // prescale below minimum runs at 4, odd parity, two stop bits
      send_frame(8'h96, 6'd2, 1, 1, 1, 1, 2'b11, -1, 0, p);
      at_period(p + 49);
      chk("t7_dv", data_valid, 1);
      chk("t7_data", P_DATA, 8'h96);
      idle(6);
      chk("events_left", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
